// File: rtl/crctab_gen_pkg.sv
// ---------------------------------------------------------------------------
// crctab_pkg : shared types and constants for the CRC table writer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package crctab_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_e;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_POLY_NORM = 32'h04C11DB7;
  localparam int          CRCTAB_DEPTH    = 256;
  localparam int          CRCTAB_AW       = 8;

endpackage

`default_nettype wire

// File: rtl/crctab_gen_step.sv
// ---------------------------------------------------------------------------
// crctab_step : combinational multi-step advance of a 32-bit Galois LFSR
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module crctab_step
  import crctab_pkg::*;
#(
  parameter logic [31:0] POLY    = CRC32_POLY_REFL,
  parameter bit          REFLECT = 1'b1,
  parameter int          STEPS   = 1
) (
  input  logic [31:0] lfsr_in,
  output logic [31:0] lfsr_out
);

  generate
    if (REFLECT) begin : g_refl
      always_comb begin
        lfsr_out = lfsr_in;
        for (int n = 0; n < STEPS; n++) begin
          lfsr_out = (lfsr_out >> 1) ^ (lfsr_out[0] ? POLY : 32'h0);
        end
      end
    end else begin : g_norm
      always_comb begin
        lfsr_out = lfsr_in;
        for (int n = 0; n < STEPS; n++) begin
          lfsr_out = (lfsr_out << 1) ^ (lfsr_out[31] ? POLY : 32'h0);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/crctab_gen.sv
// ---------------------------------------------------------------------------
// crctab_gen : computes the 256-entry CRC table and streams it to a RAM port.
// Optional signature register enabled by defining CRCTAB_GEN_SIG_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module crctab_gen
  import crctab_pkg::*;
#(
  parameter logic [31:0] POLY         = CRC32_POLY_REFL,
  parameter bit          REFLECT      = 1'b1,
  parameter int          EV_BYTES     = 1,
  parameter int          BITS_PER_CLK = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [CRCTAB_AW-1:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic [31:0]          sig
);

  localparam int                   CALC_CYCLES = (8 * EV_BYTES) / BITS_PER_CLK;
  localparam logic [6:0]           CALC_LAST   = 7'(CALC_CYCLES - 1);
  localparam logic [CRCTAB_AW-1:0] IDX_LAST    = CRCTAB_AW'(CRCTAB_DEPTH - 1);

  state_e               state_q, state_d;
  logic [CRCTAB_AW-1:0] idx_q, idx_d;
  logic [31:0]          lfsr_q, lfsr_d, lfsr_step;
  logic [6:0]           step_cnt_q, step_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [CRCTAB_AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]          wr_data_q, wr_data_d;

  crctab_step #(
    .POLY    (POLY),
    .REFLECT (REFLECT),
    .STEPS   (BITS_PER_CLK)
  ) u_step (
    .lfsr_in  (lfsr_q),
    .lfsr_out (lfsr_step)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lfsr_d     = lfsr_q;
    step_cnt_d = step_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        lfsr_d     = REFLECT ? {24'h0, idx_q} : {idx_q, 24'h0};
        step_cnt_d = '0;
        state_d    = CALC;
      end
      CALC: begin
        lfsr_d     = lfsr_step;
        step_cnt_d = step_cnt_q + 7'd1;
        // Present the finished entry straight from the step network.
        if (step_cnt_q == CALC_LAST) begin
          state_d    = WRITE;
          wr_valid_d = 1'b1;
          wr_addr_d  = idx_q;
          wr_data_d  = lfsr_step;
        end
      end
      WRITE: begin
        if (wr_ready) begin
          wr_valid_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      FIN: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lfsr_q     <= '0;
      step_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lfsr_q     <= lfsr_d;
      step_cnt_q <= step_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

`ifdef CRCTAB_GEN_SIG_EN
  logic [31:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (state_q == LOAD && idx_q == '0) begin
      sig_d = '0;
    end else if (state_q == WRITE && wr_ready) begin
      sig_d = sig_q ^ wr_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`else
  assign sig = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crctab_gen.sv
// ---------------------------------------------------------------------------
// tb_crctab_gen : self-checking bench for crctab_gen (default and look-ahead)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_crctab_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, wr_ready = 1'b1;
  logic start2 = 1'b0, ready2 = 1'b1;
  logic busy, done, wr_valid, busy2, done2, wr_valid2;
  logic [7:0]  wr_addr, wr_addr2;
  logic [31:0] wr_data, sig, wr_data2, sig2;

  always #5 clk = ~clk;

  crctab_gen dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .sig(sig)
  );

  crctab_gen #(.EV_BYTES(4), .BITS_PER_CLK(8)) dut_la (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .wr_valid(wr_valid2), .wr_ready(ready2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .sig(sig2)
  );

  int checks = 0, errors = 0, cyc = 0;
  int nwr = 0, ndone = 0, nwr2 = 0, ndone2 = 0, last_hs = 0, last_hs2 = 0;
  bit lat_chk = 1'b0, stalled = 1'b0, exp_done = 1'b0, ok;
  logic [7:0]  held_addr;
  logic [31:0] held_data, xor_ref;
  logic [31:0] tbl [256];
  logic [39:0] e_mon, e_mon2;
  logic [39:0] exp_q[$], exp2_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_entry(input int i, input int nbits);
    logic [31:0] v;
    v = 32'(i & 255);
    for (int n = 0; n < nbits; n++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
    return v;
  endfunction

  task automatic load_queue(input bit la);
    logic [31:0] e;
    xor_ref = '0;
    for (int i = 0; i < 256; i++) begin
      e = ref_entry(i, 8);
      exp_q.push_back({8'(i), e});
      xor_ref ^= e;
      if (la) exp2_q.push_back({8'(i), ref_entry(i, 32)});
    end
  endtask

  task automatic clear_counts();
    nwr = 0; ndone = 0; nwr2 = 0; ndone2 = 0;
  endtask

  task automatic pulse(input bit la);
    @(posedge clk); #1;
    start = 1'b1; start2 = la;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic run(input bit stall, input bit repulse, output bit seen);
    int budget, stall_left;
    seen = 1'b0; budget = 0; stall_left = 0;
    while (!seen && budget < 10000) begin
      @(posedge clk); #1;
      budget++;
      if (done) seen = 1'b1;
      else begin
        start = repulse && (budget % 97 == 50);
        if (stall) begin
          if (stall_left > 0) begin
            wr_ready = 1'b0; stall_left--;
          end else begin
            wr_ready = 1'b1;
            if ($urandom_range(0, 1) == 1) stall_left = int'($urandom_range(1, 5));
          end
        end
      end
    end
    start = 1'b0; wr_ready = 1'b1;
    chk("done_seen", seen, 1);
  endtask

  task automatic sig_check();
`ifdef CRCTAB_GEN_SIG_EN
    chk("sig_at_done", sig, xor_ref);
`else
    chk("sig_zero", sig, 0);
`endif
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the default-parameter instance.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0; exp_done = 1'b0;
    end else begin
      if (exp_done || done) chk("done_pulse", done, exp_done);
      exp_done = 1'b0;
      if (done) ndone++;
      if (wr_valid) begin
        if (stalled) begin
          chk("addr_stable", wr_addr, held_addr);
          chk("data_stable", wr_data, held_data);
        end
        if (wr_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) chk("write_expected", exp_q.size(), 1);
          else begin
            e_mon = exp_q.pop_front();
            chk("entry", {wr_addr, wr_data}, e_mon);
          end
          tbl[wr_addr] = wr_data;
          nwr++;
          if (lat_chk && nwr > 1) chk("entry_period", cyc - last_hs, 10);
          last_hs = cyc;
          if (wr_addr == 8'hFF) exp_done = 1'b1;
        end else begin
          stalled = 1'b1; held_addr = wr_addr; held_data = wr_data;
        end
      end else stalled = 1'b0;
    end
  end

  // Monitor for the 4-byte look-ahead instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (done2) ndone2++;
      if (wr_valid2 && ready2) begin
        if (exp2_q.size() == 0) chk("la_write_expected", exp2_q.size(), 1);
        else begin
          e_mon2 = exp2_q.pop_front();
          chk("la_entry", {wr_addr2, wr_data2}, e_mon2);
        end
        nwr2++;
        if (lat_chk && nwr2 > 1) chk("la_period", cyc - last_hs2, 6);
        last_hs2 = cyc;
      end
    end
  end

  initial begin
    bit hit;
    int budget;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", wr_valid, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_sig", sig, 0);
    chk("rst_la_valid", wr_valid2, 0);
    rst = 1'b0;

    // Full table, no stalls, alongside the look-ahead instance.
    lat_chk = 1'b1;
    clear_counts();
    load_queue(1'b1);
    pulse(1'b1);
    chk("busy_after_start", busy, 1);
    run(1'b0, 1'b0, ok);
    @(negedge clk); #1;
    lat_chk = 1'b0;
    chk("t1_writes", nwr, 256);
    chk("t1_dones", ndone, 1);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("tbl_01", tbl[8'h01], 32'h77073096);
    chk("tbl_80", tbl[8'h80], 32'hEDB88320);
    chk("tbl_ff", tbl[8'hFF], 32'h2D02EF8D);
    chk("la_writes", nwr2, 256);
    chk("la_dones", ndone2, 1);
    chk("la_queue_empty", exp2_q.size(), 0);
    sig_check();

    // Random write stalls.
    clear_counts();
    load_queue(1'b0);
    pulse(1'b0);
    run(1'b1, 1'b0, ok);
    @(negedge clk); #1;
    chk("t2_writes", nwr, 256);
    chk("t2_dones", ndone, 1);
    chk("t2_queue_empty", exp_q.size(), 0);
    sig_check();

    // start re-pulsed while busy and during FIN.
    clear_counts();
    load_queue(1'b0);
    pulse(1'b0);
    run(1'b0, 1'b1, ok);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_writes", nwr, 256);
    chk("t3_dones", ndone, 1);
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_valid", wr_valid, 0);

    // Reset while entry 0x40 is being written.
    clear_counts();
    load_queue(1'b0);
    pulse(1'b0);
    hit = 1'b0; budget = 0;
    while (!hit && budget < 5000) begin
      @(posedge clk); #1;
      budget++;
      if (wr_valid && wr_addr == 8'h40) hit = 1'b1;
    end
    wr_ready = 1'b0;
    chk("reached_0x40", hit, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_valid", wr_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", wr_addr, 0);
    chk("abort_data", wr_data, 0);
    chk("abort_sig", sig, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    wr_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_abort_idle", wr_valid, 0);
    clear_counts();
    load_queue(1'b0);
    pulse(1'b0);
    run(1'b0, 1'b0, ok);
    @(negedge clk); #1;
    chk("t4_writes", nwr, 256);
    chk("t4_dones", ndone, 1);
    chk("t4_queue_empty", exp_q.size(), 0);
    chk("t4_entry_40", tbl[8'h40], ref_entry(64, 8));
    sig_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
